// File: rtl/prbs_pkg.sv
// Shared definitions for the PRBS checker slice: sequence selection, tap
// positions of the supported polynomials and the lock state machine encoding.
package prbs_pkg;

    typedef enum int unsigned {
        PRBS7  = 7,
        PRBS15 = 15,
        PRBS23 = 23,
        PRBS31 = 31
    } prbs_sel_e;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_e;

    typedef struct packed {
        int unsigned a;
        int unsigned b;
    } taps_t;

    // Recurrence bit(n) = bit(n-a) ^ bit(n-b); unsupported orders return zeros.
    function automatic taps_t taps(input int unsigned prbs);
        taps_t t;
        case (prbs)
            7:       begin t.a = 7;  t.b = 6;  end
            15:      begin t.a = 15; t.b = 14; end
            23:      begin t.a = 23; t.b = 18; end
            31:      begin t.a = 31; t.b = 28; end
            default: begin t.a = 0;  t.b = 0;  end
        endcase
        return t;
    endfunction

endpackage

// File: rtl/prbs_checker_if.sv
// Beat stream into the PRBS checker and its lock / error status back out.
interface prbs_checker_if #(
    parameter int DataWidth = 32,
    parameter int CntWidth  = 32
);
    logic                 valid_i;
    logic [DataWidth-1:0] data_i;
    logic                 clear_i;
    logic                 locked_o;
    logic                 beat_err_o;
    logic [CntWidth-1:0]  err_cnt_o;

    modport master (
        output valid_i, data_i, clear_i,
        input  locked_o, beat_err_o, err_cnt_o
    );

    modport slave (
        input  valid_i, data_i, clear_i,
        output locked_o, beat_err_o, err_cnt_o
    );
endinterface

// File: rtl/popcount.sv
// Combinational population count of an INPUT_WIDTH-bit vector.
module popcount #(
    parameter  int INPUT_WIDTH = 32,
    localparam int CountWidth  = $clog2(INPUT_WIDTH + 1)
) (
    input  logic [INPUT_WIDTH-1:0] data_i,
    output logic [CountWidth-1:0]  count_o
);

    always_comb begin
        count_o = '0;
        for (int i = 0; i < INPUT_WIDTH; i++) begin
            count_o = count_o + CountWidth'(data_i[i]);
        end
    end

endmodule

// File: rtl/prbs_predict.sv
// Unrolls the PRBS recurrence over one beat: given the last Prbs bits
// (bit 0 oldest), produces the next DataWidth bits and the resulting history.
module prbs_predict
    import prbs_pkg::*;
#(
    parameter int Prbs      = 7,
    parameter int DataWidth = 32
) (
    input  logic [Prbs-1:0]      hist_i,
    output logic [DataWidth-1:0] pred_o,
    output logic [Prbs-1:0]      hist_o
);

    localparam taps_t Taps = taps(Prbs);
    localparam int    TapA = int'(Taps.a);
    localparam int    TapB = int'(Taps.b);

    // History occupies the low end of a scratch stream, predictions extend it upwards.
    function automatic logic [DataWidth-1:0] extend(input logic [Prbs-1:0] h);
        logic [Prbs+DataWidth-1:0] s;
        s = '0;
        s[Prbs-1:0] = h;
        for (int i = 0; i < DataWidth; i++) begin
            s[Prbs+i] = s[Prbs+i-TapA] ^ s[Prbs+i-TapB];
        end
        return s[Prbs+DataWidth-1:Prbs];
    endfunction

    assign pred_o = extend(hist_i);
    assign hist_o = pred_o[DataWidth-1 -: Prbs];

endmodule

// File: rtl/prbs_checker.sv
// Receive-side PRBS checker: seeds from the stream, verifies, then counts bit
// errors against a free-running prediction until sustained errors drop lock.
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int Prbs      = 7,
    parameter int DataWidth = 32,
    parameter int LockBeats = 4,
    parameter int LossBeats = 4,
    parameter int CntWidth  = 32
) (
    input logic            clk_i,
    input logic            rst_ni,
    prbs_checker_if.slave  bus
);

    localparam int PopWidth = $clog2(DataWidth + 1);
    localparam int SumWidth = ((CntWidth > PopWidth) ? CntWidth : PopWidth) + 1;
    localparam int GoodW    = $clog2(LockBeats + 1);
    localparam int BadW     = $clog2(LossBeats + 1);

    if (Prbs != int'(PRBS7) && Prbs != int'(PRBS15) &&
        Prbs != int'(PRBS23) && Prbs != int'(PRBS31)) begin : g_bad_prbs
        $error("prbs_checker: Prbs must be 7, 15, 23 or 31");
    end
    if (DataWidth < Prbs) begin : g_bad_width
        $error("prbs_checker: DataWidth must be >= Prbs");
    end
    if (LockBeats < 1 || LossBeats < 1) begin : g_bad_beats
        $error("prbs_checker: LockBeats and LossBeats must be >= 1");
    end

    state_e               state_q, state_d;
    logic [Prbs-1:0]      hist_q, hist_d, hist_pred;
    logic [GoodW-1:0]     good_q, good_d;
    logic [BadW-1:0]      bad_q, bad_d;
    logic [CntWidth-1:0]  cnt_q, cnt_d;
    logic                 berr_q, berr_d;
    logic [DataWidth-1:0] pred;
    logic [PopWidth-1:0]  pop;
    logic [SumWidth-1:0]  sum;
    logic [Prbs-1:0]      seed;

    prbs_predict #(
        .Prbs      (Prbs),
        .DataWidth (DataWidth)
    ) u_predict (
        .hist_i (hist_q),
        .pred_o (pred),
        .hist_o (hist_pred)
    );

    popcount #(
        .INPUT_WIDTH (DataWidth)
    ) u_popcount (
        .data_i  (bus.data_i ^ pred),
        .count_o (pop)
    );

    assign seed = bus.data_i[DataWidth-1 -: Prbs];
    assign sum  = SumWidth'(cnt_q) + SumWidth'(pop);

    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        good_d  = good_q;
        bad_d   = bad_q;
        cnt_d   = cnt_q;
        berr_d  = 1'b0;
        if (bus.valid_i) begin
            unique case (state_q)
                HUNT: begin
                    hist_d = seed;
                    good_d = '0;
                    if (|seed) state_d = VERIFY;
                end
                VERIFY: begin
                    hist_d = seed;
                    if (pop != '0) begin
                        state_d = HUNT;
                    end else if (good_q == GoodW'(LockBeats - 1)) begin
                        state_d = LOCKED;
                        bad_d   = '0;
                    end else begin
                        good_d = good_q + 1'b1;
                    end
                end
                LOCKED: begin
                    // Follow our own prediction so a flipped bit is charged exactly once.
                    hist_d = hist_pred;
                    cnt_d  = (|sum[SumWidth-1:CntWidth]) ? '1 : sum[CntWidth-1:0];
                    if (pop != '0) begin
                        berr_d = 1'b1;
                        if (bad_q == BadW'(LossBeats - 1)) state_d = HUNT;
                        else                               bad_d   = bad_q + 1'b1;
                    end else begin
                        bad_d = '0;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
        if (bus.clear_i) cnt_d = '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= HUNT;
            hist_q  <= '0;
            good_q  <= '0;
            bad_q   <= '0;
            cnt_q   <= '0;
            berr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            good_q  <= good_d;
            bad_q   <= bad_d;
            cnt_q   <= cnt_d;
            berr_q  <= berr_d;
        end
    end

    assign bus.locked_o   = (state_q == LOCKED);
    assign bus.beat_err_o = berr_q;
    assign bus.err_cnt_o  = cnt_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Scoreboard bench for prbs_checker: three instances (PRBS7 main, PRBS7 with a
// 4-bit counter, PRBS31 with gapped valid) driven from directed vectors.
module tb_prbs_checker;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    prbs_checker_if #(.DataWidth(32), .CntWidth(32)) ifA ();
    prbs_checker_if #(.DataWidth(32), .CntWidth(4))  ifB ();
    prbs_checker_if #(.DataWidth(32), .CntWidth(32)) ifC ();

    prbs_checker #(.Prbs(7), .DataWidth(32), .LockBeats(4), .LossBeats(4), .CntWidth(32))
        dutA (.clk_i(clk), .rst_ni(rst_n), .bus(ifA));
    prbs_checker #(.Prbs(7), .DataWidth(32), .LockBeats(4), .LossBeats(8), .CntWidth(4))
        dutB (.clk_i(clk), .rst_ni(rst_n), .bus(ifB));
    prbs_checker #(.Prbs(31), .DataWidth(32), .LockBeats(4), .LossBeats(4), .CntWidth(32))
        dutC (.clk_i(clk), .rst_ni(rst_n), .bus(ifC));

    typedef struct {
        int          id;
        string       name;
        logic        locked;
        logic        berr;
        logic [31:0] cnt;
    } exp_t;

    exp_t        expQ[$];
    exp_t        monE;
    int          checks = 0;
    int          errors = 0;
    logic [30:0] genHist;

    // Compare one observed value against its expectation and keep the tallies.
    function automatic void checkOutput(input string name, input logic [31:0] got,
                                        input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, got, want);
        end
    endfunction

    // Bit-serial reference generator; genHist[0] is the most recent bit.
    task automatic genBeat(input int prbs, output logic [31:0] beat);
        int   a;
        int   b;
        logic nb;
        case (prbs)
            15:      begin a = 15; b = 14; end
            23:      begin a = 23; b = 18; end
            31:      begin a = 31; b = 28; end
            default: begin a = 7;  b = 6;  end
        endcase
        for (int i = 0; i < 32; i++) begin
            nb      = genHist[a-1] ^ genHist[b-1];
            beat[i] = nb;
            genHist = {genHist[29:0], nb};
        end
    endtask

    // Drive one valid beat on the chosen instance and queue what it should produce.
    task automatic applyStimulus(input int id, input logic [31:0] data, input logic clear,
                                 input string name, input logic expLocked,
                                 input logic expBerr, input logic [31:0] expCnt);
        exp_t e;
        @(negedge clk);
        case (id)
            0:       begin ifA.valid_i = 1'b1; ifA.data_i = data; ifA.clear_i = clear; end
            1:       begin ifB.valid_i = 1'b1; ifB.data_i = data; ifB.clear_i = clear; end
            default: begin ifC.valid_i = 1'b1; ifC.data_i = data; ifC.clear_i = clear; end
        endcase
        e.id     = id;
        e.name   = name;
        e.locked = expLocked;
        e.berr   = expBerr;
        e.cnt    = expCnt;
        expQ.push_back(e);
        @(posedge clk);
        #1;
        ifA.valid_i = 1'b0; ifA.clear_i = 1'b0;
        ifB.valid_i = 1'b0; ifB.clear_i = 1'b0;
        ifC.valid_i = 1'b0; ifC.clear_i = 1'b0;
    endtask

    // Monitor: after every active edge, pop the pending expectation and compare.
    always begin
        @(posedge clk);
        #2;
        if (expQ.size() > 0) begin
            monE = expQ.pop_front();
            case (monE.id)
                0: begin
                    checkOutput({monE.name, " locked"}, 32'(ifA.locked_o), 32'(monE.locked));
                    checkOutput({monE.name, " beat_err"}, 32'(ifA.beat_err_o), 32'(monE.berr));
                    checkOutput({monE.name, " err_cnt"}, ifA.err_cnt_o, monE.cnt);
                end
                1: begin
                    checkOutput({monE.name, " locked"}, 32'(ifB.locked_o), 32'(monE.locked));
                    checkOutput({monE.name, " beat_err"}, 32'(ifB.beat_err_o), 32'(monE.berr));
                    checkOutput({monE.name, " err_cnt"}, {28'b0, ifB.err_cnt_o}, monE.cnt);
                end
                default: begin
                    checkOutput({monE.name, " locked"}, 32'(ifC.locked_o), 32'(monE.locked));
                    checkOutput({monE.name, " beat_err"}, 32'(ifC.beat_err_o), 32'(monE.berr));
                    checkOutput({monE.name, " err_cnt"}, ifC.err_cnt_o, monE.cnt);
                end
            endcase
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] b;
        logic [31:0] cnt;
        int          acc;

        ifA.valid_i = 1'b0; ifA.data_i = '0; ifA.clear_i = 1'b0;
        ifB.valid_i = 1'b0; ifB.data_i = '0; ifB.clear_i = 1'b0;
        ifC.valid_i = 1'b0; ifC.data_i = '0; ifC.clear_i = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        checkOutput("reset A locked", 32'(ifA.locked_o), 32'd0);
        checkOutput("reset A beat_err", 32'(ifA.beat_err_o), 32'd0);
        checkOutput("reset A err_cnt", ifA.err_cnt_o, 32'd0);
        checkOutput("reset B err_cnt", {28'b0, ifB.err_cnt_o}, 32'd0);
        checkOutput("reset C locked", 32'(ifC.locked_o), 32'd0);
        #9 rst_n = 1'b1;

        // All-zero stream never seeds.
        for (int k = 1; k <= 10; k++)
            applyStimulus(0, 32'h0, 1'b0, $sformatf("zero b%0d", k), 1'b0, 1'b0, 32'd0);

        // Clean PRBS7 stream: lock after seed + 4 clean beats.
        genHist = '1;
        for (int k = 1; k <= 100; k++) begin
            genBeat(7, b);
            applyStimulus(0, b, 1'b0, $sformatf("lock b%0d", k), (k >= 5), 1'b0, 32'd0);
        end

        // One flipped bit is counted once and does not disturb lock.
        for (int j = 1; j <= 30; j++) begin
            genBeat(7, b);
            if (j == 20) b[5] = ~b[5];
            applyStimulus(0, b, 1'b0, $sformatf("flip b%0d", j), 1'b1, (j == 20),
                          (j >= 20) ? 32'd1 : 32'd0);
        end

        // Four zero beats: every predicted one is a mismatch, lock drops on the fourth.
        cnt = 32'd1;
        for (int j = 1; j <= 4; j++) begin
            genBeat(7, b);
            cnt = cnt + 32'($countones(b));
            applyStimulus(0, 32'h0, 1'b0, $sformatf("loss b%0d", j), (j < 4), 1'b1, cnt);
        end
        for (int r = 1; r <= 10; r++) begin
            genBeat(7, b);
            applyStimulus(0, b, 1'b0, $sformatf("relock b%0d", r), (r >= 5), 1'b0, cnt);
        end

        // Asynchronous reset while locked clears everything at once.
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset locked", 32'(ifA.locked_o), 32'd0);
        checkOutput("midreset beat_err", 32'(ifA.beat_err_o), 32'd0);
        checkOutput("midreset err_cnt", ifA.err_cnt_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            genBeat(7, b);
            applyStimulus(0, b, 1'b0, $sformatf("postreset b%0d", k), (k >= 5), 1'b0, 32'd0);
        end

        // 4-bit counter saturates, then clear beats a simultaneous errored beat.
        genHist = '1;
        for (int k = 1; k <= 5; k++) begin
            genBeat(7, b);
            applyStimulus(1, b, 1'b0, $sformatf("satlock b%0d", k), (k >= 5), 1'b0, 32'd0);
        end
        for (int k = 1; k <= 6; k++) begin
            genBeat(7, b);
            applyStimulus(1, b ^ 32'h0010_0401, 1'b0, $sformatf("sat b%0d", k), 1'b1, 1'b1,
                          (3 * k > 15) ? 32'd15 : 32'(3 * k));
        end
        genBeat(7, b);
        applyStimulus(1, b ^ 32'h0000_0006, 1'b1, "clear", 1'b1, 1'b1, 32'd0);
        genBeat(7, b);
        applyStimulus(1, b, 1'b0, "postclear", 1'b1, 1'b0, 32'd0);

        // PRBS31 with gapped valid: lock counts accepted beats only.
        genHist = '1;
        acc = 0;
        while (acc < 1000) begin
            if ($urandom_range(0, 1) == 0) begin
                @(posedge clk);
            end else begin
                genBeat(31, b);
                acc++;
                applyStimulus(2, b, 1'b0, $sformatf("p31 b%0d", acc), (acc >= 5), 1'b0, 32'd0);
            end
        end

        for (int i = 0; i < 10 && expQ.size() > 0; i++) @(posedge clk);
        #3;
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d pending, want 0", expQ.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
